// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger/window capture logic.
package trig_pkg;

    // Window controller states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLDOFF = 2'd2
    } state_e;

    // Trigger source select encodings
    localparam logic [1:0] TRIG_SEL_NONE = 2'b00;
    localparam logic [1:0] TRIG_SEL_EXT  = 2'b01;
    localparam logic [1:0] TRIG_SEL_INT  = 2'b10;
    localparam logic [1:0] TRIG_SEL_ANY  = 2'b11;

    // Width of the shared sample/holdoff down-counter. The counter only ever
    // holds WIN_LEN-1 or HOLDOFF-1, so clog2 of the larger length suffices.
    function automatic int cnt_width(input int win_len, input int holdoff);
        int m;
        m = (win_len > holdoff) ? win_len : holdoff;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/trig_window_ctrl_if.sv
// FIFO write-port handshake between the window controller and the data FIFO.
interface trig_window_ctrl_if;
    logic fifo_wrreq;
    logic fifo_full;

    modport master (output fifo_wrreq, input fifo_full);
    modport slave  (input fifo_wrreq, output fifo_full);
endinterface

// File: rtl/trig_edge_det.sv
// Trigger source select followed by a two-stage register and a one-cycle
// rising-edge pulse. A level-high trigger produces exactly one pulse.
module trig_edge_det
    import trig_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] trig_sel,
    input  logic       trig_ext,
    input  logic       trig_int,
    output logic       trig_edge
);

    logic sel_d;
    logic t_q, t_d;
    logic t_q2, t_d2;

    // Combine the enabled sources and feed the delay line
    always_comb begin
        sel_d = ((trig_sel & TRIG_SEL_EXT) != 2'b00 && trig_ext) ||
                ((trig_sel & TRIG_SEL_INT) != 2'b00 && trig_int);
        t_d   = sel_d;
        t_d2  = t_q;
    end

    // Two-stage trigger register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q  <= 1'b0;
            t_q2 <= 1'b0;
        end else begin
            t_q  <= t_d;
            t_q2 <= t_d2;
        end
    end

    assign trig_edge = t_q & ~t_q2;

endmodule

// File: rtl/trig_window_ctrl.sv
// Trigger-driven write-window controller for one ADC channel's FIFO write
// port: accepts a trigger edge, opens a fixed-length window, then holds off.
// Also maintains event / lost-trigger counters and a sticky overflow flag.
module trig_window_ctrl
    import trig_pkg::*;
#(
    parameter int WIN_LEN = 256,
    parameter int HOLDOFF = 16,
    parameter int EVT_W   = 32,
    parameter int LOST_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic [1:0]            trig_sel,
    input  logic                  trig_ext,
    input  logic                  trig_int,
    input  logic                  clr_cnt,
    trig_window_ctrl_if.master    fifo,
    output logic                  busy,
    output logic [EVT_W-1:0]      evt_cnt,
    output logic [LOST_W-1:0]     lost_cnt,
    output logic                  overflow
);

    localparam int CNT_W = cnt_width(WIN_LEN, HOLDOFF);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);
    // Only used when HOLDOFF != 0
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    logic              trig_edge;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic [LOST_W-1:0] lost_q, lost_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              wrreq;
    logic              reject;

    trig_edge_det u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_sel  (trig_sel),
        .trig_ext  (trig_ext),
        .trig_int  (trig_int),
        .trig_edge (trig_edge)
    );

    // Next-state, window counter, bookkeeping and write gating
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = evt_q;
        lost_d  = lost_q;
        ovf_d   = ovf_q;
        wrreq   = 1'b0;
        reject  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_edge && arm) begin
                    if (!fifo.fifo_full) begin
                        state_d = S_CAPTURE;
                        cnt_d   = WIN_LAST;
                        evt_d   = evt_q + 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                // Window is fixed in time: count on even while the FIFO is full
                wrreq = ~fifo.fifo_full;
                if (fifo.fifo_full) ovf_d = 1'b1;
                if (trig_edge && arm) reject = 1'b1;
                if (cnt_q == '0) begin
                    if (HOLDOFF != 0) begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HOLD_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (trig_edge && arm) reject = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Lost-trigger counter saturates rather than wrapping
        if (reject && (lost_q != '1)) lost_d = lost_q + 1'b1;

        // Host clear wins over any same-cycle increment or set
        if (clr_cnt) begin
            evt_d  = '0;
            lost_d = '0;
            ovf_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            evt_q   <= '0;
            lost_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    // wrreq decodes the registered state, so reset drops it asynchronously
    assign fifo.fifo_wrreq = wrreq;
    assign busy            = busy_q;
    assign evt_cnt         = evt_q;
    assign lost_cnt        = lost_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_trig_window_ctrl.sv
// Directed bench for trig_window_ctrl. Instance A: WIN_LEN=8, HOLDOFF=4.
// Instance B: WIN_LEN=8, HOLDOFF=0, LOST_W=4 (back-to-back and saturation).
module tb_trig_window_ctrl;
    import trig_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, arm, clr, trig_ext, trig_int, full;
    logic [1:0]  trig_sel;
    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [31:0] evt_a, evt_b;
    logic [15:0] lost_a;
    logic [3:0]  lost_b;
    int          wr_a = 0;
    int          wr_b = 0;
    int          base;
    int          n_chk = 0;
    int          n_fail = 0;

    trig_window_ctrl_if ifa ();
    trig_window_ctrl_if ifb ();
    assign ifa.fifo_full = full;
    assign ifb.fifo_full = full;

    trig_window_ctrl #(.WIN_LEN(8), .HOLDOFF(4), .EVT_W(32), .LOST_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_sel(trig_sel),
        .trig_ext(trig_ext), .trig_int(trig_int), .clr_cnt(clr),
        .fifo(ifa.master), .busy(busy_a), .evt_cnt(evt_a),
        .lost_cnt(lost_a), .overflow(ovf_a));

    trig_window_ctrl #(.WIN_LEN(8), .HOLDOFF(0), .EVT_W(32), .LOST_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_sel(trig_sel),
        .trig_ext(trig_ext), .trig_int(trig_int), .clr_cnt(clr),
        .fifo(ifb.master), .busy(busy_b), .evt_cnt(evt_b),
        .lost_cnt(lost_b), .overflow(ovf_b));

    always #5 clk = ~clk;

    // Count FIFO writes as the FIFO would see them
    always @(posedge clk) begin
        if (ifa.fifo_wrreq) wr_a <= wr_a + 1;
        if (ifb.fifo_wrreq) wr_b <= wr_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; clr = 1'b0; trig_ext = 1'b0; trig_int = 1'b0;
        full = 1'b0; trig_sel = TRIG_SEL_NONE;
        tick(); tick();
        chk("rst_wrreq", ifa.fifo_wrreq, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_evt", evt_a, 0);
        chk("rst_lost", lost_a, 0);
        chk("rst_ovf", ovf_a, 0);
        rst_n = 1'b1;
        tick();

        // 1: held-high ext trigger, one window and holdoff
        arm = 1'b1; trig_sel = TRIG_SEL_EXT; trig_ext = 1'b1;
        tick();                                  // cycle N+1
        chk("t1_wr_n1", ifa.fifo_wrreq, 0);
        for (int i = 0; i < 8; i++) begin
            tick();                              // cycles N+2..N+9
            chk("t1_wr_on", ifa.fifo_wrreq, 1);
        end
        chk("t1_evt", evt_a, 1);
        tick();                                  // N+10: holdoff
        chk("t1_wr_off", ifa.fifo_wrreq, 0);
        chk("t1_busy_hold", busy_a, 1);
        chk("t1_b_busy_nohold", busy_b, 0);
        tick(); tick(); tick();                  // N+13: last holdoff cycle
        chk("t1_busy_last", busy_a, 1);
        tick();                                  // N+14
        chk("t1_busy_end", busy_a, 0);
        chk("t1_lost", lost_a, 0);
        trig_ext = 1'b0;

        // 2: second pulse inside window is lost; pulse after holdoff accepted
        pulse_clr();
        chk("t2_clr_evt", evt_a, 0);
        base = wr_a;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        tick(); tick();
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        repeat (20) tick();
        chk("t2_writes", wr_a - base, 8);
        chk("t2_evt", evt_a, 1);
        chk("t2_lost", lost_a, 1);
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        repeat (20) tick();
        chk("t2_writes2", wr_a - base, 16);
        chk("t2_evt2", evt_a, 2);
        chk("t2_lost2", lost_a, 1);

        // 3: fifo_full for two window cycles drops two samples, window length fixed
        pulse_clr();
        base = wr_a;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;     // N+1
        tick(); tick();                                // N+3
        chk("t3_wr_pre", ifa.fifo_wrreq, 1);
        tick(); full = 1'b1; #1;                       // N+4
        chk("t3_wr_full1", ifa.fifo_wrreq, 0);
        tick(); #1;                                    // N+5
        chk("t3_wr_full2", ifa.fifo_wrreq, 0);
        tick(); full = 1'b0; #1;                       // N+6
        chk("t3_wr_resume", ifa.fifo_wrreq, 1);
        chk("t3_ovf_set", ovf_a, 1);
        tick(); tick(); tick();                        // N+9
        chk("t3_wr_last", ifa.fifo_wrreq, 1);
        tick();                                        // N+10
        chk("t3_wr_end", ifa.fifo_wrreq, 0);
        repeat (6) tick();
        chk("t3_writes", wr_a - base, 6);
        chk("t3_ovf_sticky", ovf_a, 1);
        chk("t3_b_ovf", ovf_b, 1);
        pulse_clr();
        chk("t3_ovf_clr", ovf_a, 0);

        // 4: trigger while FIFO full in IDLE, clear priority, arm=0 ignores
        full = 1'b1;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;     // edge visible this cycle
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr_prio", lost_a, 0);
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        tick(); tick();
        chk("t4_lost", lost_a, 1);
        chk("t4_evt", evt_a, 0);
        chk("t4_busy", busy_a, 0);
        chk("t4_wr", ifa.fifo_wrreq, 0);
        full = 1'b0; arm = 1'b0;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        repeat (4) tick();
        chk("t4_noarm_lost", lost_a, 1);
        chk("t4_noarm_evt", evt_a, 0);
        chk("t4_noarm_busy", busy_a, 0);
        arm = 1'b1;

        // 5: internal trigger window, then sel=none with toggling inputs
        pulse_clr();
        base = wr_a;
        trig_sel = TRIG_SEL_INT; trig_int = 1'b1; tick(); trig_int = 1'b0;
        trig_sel = TRIG_SEL_NONE;
        repeat (30) begin
            trig_ext = ~trig_ext; trig_int = ~trig_int;
            tick();
        end
        trig_ext = 1'b0; trig_int = 1'b0;
        chk("t5_evt", evt_a, 1);
        chk("t5_writes", wr_a - base, 8);
        chk("t5_lost", lost_a, 0);
        // 20 rejected edges: A counts them, B's 4-bit counter saturates
        pulse_clr();
        trig_sel = TRIG_SEL_EXT; full = 1'b1;
        repeat (40) begin
            trig_ext = ~trig_ext;
            tick();
        end
        trig_ext = 1'b0;
        tick(); tick();
        chk("t5_lost_a", lost_a, 20);
        chk("t5_lost_sat", lost_b, 4'hF);
        full = 1'b0;
        pulse_clr();

        // 6: asynchronous reset mid-window, then a clean full window
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;     // N+1
        tick(); tick(); tick(); tick();                // N+5
        chk("t6_wr_pre", ifa.fifo_wrreq, 1);
        chk("t6_evt_pre", evt_a, 1);
        rst_n = 1'b0; #1;
        chk("t6_rst_wr", ifa.fifo_wrreq, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_evt", evt_a, 0);
        tick(); rst_n = 1'b1; tick();
        base = wr_a;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        repeat (14) tick();
        chk("t6_writes", wr_a - base, 8);
        chk("t6_evt", evt_a, 1);

        // 6b: HOLDOFF=0, re-trigger right after window -> two-cycle wrreq gap
        pulse_clr();
        base = wr_b;
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;     // N+1
        repeat (8) tick();                             // N+9
        chk("t6b_wr_last", ifb.fifo_wrreq, 1);
        tick();                                        // N+10
        chk("t6b_gap1", ifb.fifo_wrreq, 0);
        chk("t6b_idle", busy_b, 0);
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;     // N+11
        chk("t6b_gap2", ifb.fifo_wrreq, 0);
        tick();                                        // N+12
        chk("t6b_wr_again", ifb.fifo_wrreq, 1);
        repeat (10) tick();
        chk("t6b_writes", wr_b - base, 16);
        chk("t6b_evt", evt_b, 2);
        chk("t6b_lost", lost_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
